// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/country signal controller and the
// country-road vehicle detector: light codes and departure FSM states.
package traffic_pkg;

    // Light codes as driven on the controller's cntry/hwy buses.
    // Code 3 is unused and is treated as "not green" by consumers.
    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // Departure FSM: WAIT idles until the country light turns green with
    // vehicles queued; SERVE retires one vehicle per departure interval.
    typedef enum logic {
        WAIT  = 1'b0,
        SERVE = 1'b1
    } depart_state_e;

    // Only the exact GREEN code counts as green; RED, YELLOW and 3 do not.
    function automatic logic is_green(input logic [1:0] code);
        return (code == GREEN);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a debounce filter.  A new sensor level
// is only accepted after it has been seen for DEBOUNCE_CYCLES consecutive
// cycles; anything shorter is treated as a glitch.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic clear_n,
    input  logic din,
    output logic dout
);

    // Counter width must hold DEBOUNCE_CYCLES-1 and never be zero bits wide.
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q;
    logic          stable_d;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;

    // Bring the asynchronous sensor into the clock domain.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    // Count how long the synchronized level has disagreed with the accepted
    // level; adopt it once the disagreement has lasted long enough.
    always_comb begin
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        if (s2_q == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_MAX) begin
            stable_d = s2_q;
            dcnt_d   = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    // Debounce state register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            stable_q <= 1'b0;
            dcnt_q   <= '0;
        end else begin
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/vehicle_detector.sv
// Country-road vehicle detector.  Debounces the inductive loop, counts
// queued vehicles, retires them while the country light is green and raises
// X to the signal controller whenever anything is waiting.
module vehicle_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPART_CYCLES   = 3,
    parameter int COUNT_W         = 4
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               loop_raw,
    input  logic [1:0]         cntry,
    output logic               X,
    output logic [COUNT_W-1:0] car_count,
    output logic               arrive,
    output logic               depart,
    output logic               overflow
);

    // Departure interval counter must hold DEPART_CYCLES-1, at least one bit.
    localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [TW-1:0]      TCNT_MAX  = TW'(DEPART_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic               stable;
    logic               stablePrev_q;
    logic               arrive_q;
    logic               depart_q;
    logic               depart_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               overflow_q;
    logic               overflow_d;
    logic [TW-1:0]      tcnt_q;
    logic [TW-1:0]      tcnt_d;
    depart_state_e      state_q;
    depart_state_e      state_d;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .clear_n(clear_n),
        .din    (loop_raw),
        .dout   (stable)
    );

    // One-cycle arrival pulse on each accepted 0->1 sensor transition.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            stablePrev_q <= 1'b0;
            arrive_q     <= 1'b0;
        end else begin
            stablePrev_q <= stable;
            arrive_q     <= stable & ~stablePrev_q;
        end
    end

    // Queue depth follows the registered pulses one edge later; a coincident
    // arrival and departure cancel, and an arrival into a full queue is lost.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        case ({arrive_q, depart_q})
            2'b10: begin
                if (count_q == COUNT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            2'b01: begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Departure FSM: serve on green, one vehicle per DEPART_CYCLES cycles.
    // The exit check uses the count as it will be after this edge so that
    // a vehicle already retired is never retired twice.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        depart_d = 1'b0;
        case (state_q)
            WAIT: begin
                if (is_green(cntry) && (count_q != '0)) begin
                    state_d = SERVE;
                    tcnt_d  = '0;
                end
            end
            SERVE: begin
                if (!is_green(cntry)) begin
                    state_d = WAIT;
                    tcnt_d  = '0;
                end else begin
                    if (tcnt_q == TCNT_MAX) begin
                        tcnt_d   = '0;
                        depart_d = (count_d != '0);
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                    if (count_d == '0) begin
                        state_d = WAIT;
                        tcnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = WAIT;
                tcnt_d  = '0;
            end
        endcase
    end

    // State, interval counter, queue counter and sticky overflow registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= WAIT;
            tcnt_q     <= '0;
            depart_q   <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            depart_q   <= depart_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign X         = (count_q != '0);
    assign car_count = count_q;
    assign arrive    = arrive_q;
    assign depart    = depart_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_vehicle_detector.sv
// Bench for the country-road vehicle detector: table of loop pulses with
// expected queue state, a scoreboard of expected arrive/depart cycles, and
// hand-written service, interruption, coincidence and reset sequences.
module tb_vehicle_detector;

    localparam int DEB     = 4;
    localparam int DEP     = 3;
    localparam int COUNT_W = 4;

    localparam logic [1:0] L_RED    = 2'd0;
    localparam logic [1:0] L_YELLOW = 2'd1;
    localparam logic [1:0] L_GREEN  = 2'd2;
    localparam logic [1:0] L_BAD    = 2'd3;

    logic               clock;
    logic               clear_n;
    logic               loop_raw;
    logic [1:0]         cntry;
    logic               X;
    logic [COUNT_W-1:0] car_count;
    logic               arrive;
    logic               depart;
    logic               overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int arrQ[$];
    int depQ[$];

    typedef struct {
        int         pulseLen;
        logic [1:0] light;
        bit         expArrive;
        int         expCount;
        bit         expX;
        bit         expOvf;
    } vec_t;

    vec_t vecs[5];

    vehicle_detector #(
        .DEBOUNCE_CYCLES(DEB),
        .DEPART_CYCLES  (DEP),
        .COUNT_W        (COUNT_W)
    ) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .loop_raw (loop_raw),
        .cntry    (cntry),
        .X        (X),
        .car_count(car_count),
        .arrive   (arrive),
        .depart   (depart),
        .overflow (overflow)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard: every arrive/depart pulse must match the next expected cycle.
    always begin
        @(posedge clock);
        cyc++;
        #1;
        if (arrive) begin
            if (arrQ.size() == 0) checkOutput("unexpected_arrive", cyc, -1);
            else                  checkOutput("arrive_cycle", cyc, arrQ.pop_front());
        end
        if (depart) begin
            if (depQ.size() == 0) checkOutput("unexpected_depart", cyc, -1);
            else                  checkOutput("depart_cycle", cyc, depQ.pop_front());
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive one loop pulse of len cycles, then let the sensor settle low.
    task automatic applyStimulus(input int len, input bit expArrive);
        loop_raw = 1'b1;
        if (expArrive) arrQ.push_back(cyc + 3 + DEB);
        tick(len);
        loop_raw = 1'b0;
        tick(12);
    endtask

    task automatic checkQueue(input string tag, input int cnt, input int xv, input int ov);
        checkOutput({tag, "_count"}, int'(car_count), cnt);
        checkOutput({tag, "_X"}, int'(X), xv);
        checkOutput({tag, "_overflow"}, int'(overflow), ov);
    endtask

    initial begin
        int c;
        vecs[0] = '{pulseLen: 3,  light: L_RED,    expArrive: 1'b0, expCount: 0, expX: 1'b0, expOvf: 1'b0};
        vecs[1] = '{pulseLen: 10, light: L_RED,    expArrive: 1'b1, expCount: 1, expX: 1'b1, expOvf: 1'b0};
        vecs[2] = '{pulseLen: 1,  light: L_RED,    expArrive: 1'b0, expCount: 1, expX: 1'b1, expOvf: 1'b0};
        vecs[3] = '{pulseLen: 4,  light: L_YELLOW, expArrive: 1'b1, expCount: 2, expX: 1'b1, expOvf: 1'b0};
        vecs[4] = '{pulseLen: 6,  light: L_BAD,    expArrive: 1'b1, expCount: 3, expX: 1'b1, expOvf: 1'b0};

        clear_n  = 1'b0;
        loop_raw = 1'b0;
        cntry    = L_RED;
        tick(3);
        checkQueue("reset", 0, 0, 0);
        checkOutput("reset_arrive", int'(arrive), 0);
        checkOutput("reset_depart", int'(depart), 0);
        clear_n = 1'b1;
        tick(2);

        // Arrivals and glitches under non-green lights.
        for (int i = 0; i < 5; i++) begin
            cntry = vecs[i].light;
            applyStimulus(vecs[i].pulseLen, vecs[i].expArrive);
            checkQueue($sformatf("vec%0d", i), vecs[i].expCount, int'(vecs[i].expX), int'(vecs[i].expOvf));
        end

        // Continuous green drains three vehicles.
        cntry = L_GREEN;
        c = cyc;
        for (int n = 1; n <= 3; n++) depQ.push_back(c + 1 + DEP * n);
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (cyc == c + 10) checkQueue("svc_last", 1, 1, 0);
            if (cyc == c + 11) checkQueue("svc_empty", 0, 0, 0);
        end
        cntry = L_RED;
        tick(2);

        // Interrupted service discards the partial interval.
        applyStimulus(6, 1'b1);
        applyStimulus(6, 1'b1);
        checkQueue("int_start", 2, 1, 0);
        cntry = L_GREEN;
        tick(2);
        cntry = L_YELLOW;
        tick(5);
        checkQueue("int_yellow", 2, 1, 0);
        cntry = L_GREEN;
        c = cyc;
        depQ.push_back(c + 1 + DEP);
        tick(1 + DEP);
        cntry = L_RED;
        tick(3);
        checkQueue("int_resume", 1, 1, 0);

        // Arrival and departure pulses coincide at count 1.
        c = cyc;
        loop_raw = 1'b1;
        arrQ.push_back(c + 3 + DEB);
        tick(3);
        cntry = L_GREEN;
        depQ.push_back(cyc + 1 + DEP);
        tick(4);
        cntry = L_RED;
        tick(2);
        checkQueue("coincide", 1, 1, 0);
        tick(1);
        loop_raw = 1'b0;
        tick(12);
        checkQueue("coincide_settle", 1, 1, 0);

        // Saturation from an empty queue.
        clear_n = 1'b0;
        tick(1);
        clear_n = 1'b1;
        tick(1);
        checkQueue("sat_start", 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(5, 1'b1);
            checkQueue($sformatf("sat%0d", i), (i < 15) ? i + 1 : 15, 1, (i == 15) ? 1 : 0);
        end

        // Asynchronous reset in the middle of service.
        cntry = L_GREEN;
        tick(2);
        #2;
        clear_n = 1'b0;
        #1;
        checkQueue("async_rst", 0, 0, 0);
        checkOutput("async_rst_arrive", int'(arrive), 0);
        checkOutput("async_rst_depart", int'(depart), 0);
        cntry = L_RED;
        tick(2);
        clear_n = 1'b1;
        tick(4);
        checkQueue("post_rst", 0, 0, 0);

        checkOutput("arrQ_drained", arrQ.size(), 0);
        checkOutput("depQ_drained", depQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vehicle_detector.md
# vehicle_detector

- Country-road vehicle detector.
- Produces the `X` request input consumed by the highway/country signal controller, and observes that controller's `cntry` light code.
- Synchronizes and debounces a raw inductive-loop sensor, counts queued vehicles, retires them while the country light is green, and holds `X` high while any vehicle is waiting.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a changed sensor level must persist before it is accepted; legal range ≥ 1.
- `DEPART_CYCLES`, default 3: country-green cycles consumed per departing vehicle; legal range ≥ 1.
- `COUNT_W`, default 4: width of the queue counter; maximum queue = 2^COUNT_W − 1.
- `clock  input  1`: single clock; every flop is rising-edge.
- `clear_n  input  1`: asynchronous, active-low reset.
- `loop_raw  input  1`: raw loop sensor; asynchronous to `clock`; high = vehicle over loop.
- `cntry  input  2`: country light code from the controller (RED=0, YELLOW=1, GREEN=2).
- `X  output  1`: vehicle-waiting request to the controller.
- `car_count  output  COUNT_W`: current queue depth.
- `arrive  output  1`: one-cycle pulse per accepted vehicle arrival.
- `depart  output  1`: one-cycle pulse per retired vehicle.
- `overflow  output  1`: sticky; set when an arrival is dropped because the queue is full.

## Operation
- **Synchronizer:** two flops, `loop_raw` → `s1` → `s2`.
- **Debounce:**
  - `stable` is the accepted sensor level. `dcnt` counts consecutive cycles with `s2 != stable`.
  - When `s2 == stable`: `dcnt` ← 0.
  - When `s2 != stable` and `dcnt == DEBOUNCE_CYCLES-1`: `stable` ← `s2` and `dcnt` ← 0.
  - Otherwise: `dcnt` increments.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach `stable`.
- **Arrival:** `arrive` is registered. It is high for exactly the one cycle after `stable` goes 0→1. A 1→0 change produces no pulse.
- **Departure FSM:**
  - States: WAIT, SERVE.
  - WAIT→SERVE when `cntry == GREEN` and `car_count != 0`. `tcnt` ← 0 on this transition.
  - In SERVE, `tcnt` increments each cycle.
  - When `tcnt == DEPART_CYCLES-1`, pulse `depart` (registered, one cycle) and reset `tcnt` to 0.
  - SERVE stays in SERVE while `cntry == GREEN` and the post-update count is nonzero; otherwise it returns to WAIT.
  - SERVE→WAIT immediately whenever `cntry != GREEN`. `tcnt` is cleared and a partial interval is discarded (no depart).
- **Counter update**, applied the edge after the `arrive`/`depart` pulse:
  - Arrive only: +1, saturating at the maximum. An arrival at the maximum sets `overflow` and leaves the count unchanged.
  - Depart only: −1. `depart` never fires at count 0.
  - Both in the same cycle: count unchanged, `overflow` unaffected.
- `X = (car_count != 0)`, decoded directly from the registered count; no extra flop.
- `overflow` clears only on reset.
- YELLOW and RED both count as "not green". Code 3 is treated as not green.

## Timing
- **Reset (asynchronous, `clear_n` low):**
  - `s1`, `s2`, `stable`, `dcnt`, `tcnt`: 0.
  - FSM = WAIT.
  - `X` = 0, `car_count` = 0, `arrive` = 0, `depart` = 0, `overflow` = 0.
  - Reset asserted mid-SERVE or mid-debounce abandons all progress. Release is synchronous to the next rising edge.
- **Arrival latency:** `loop_raw` rises and is captured at edge k. Then:
  - `s2` = 1 after edge k+1.
  - `stable` = 1 after edge k+1+DEBOUNCE_CYCLES.
  - `arrive` = 1 after edge k+2+DEBOUNCE_CYCLES.
  - `car_count`/`X` update after edge k+3+DEBOUNCE_CYCLES.
  - With default parameters: 7 edges.
- **Departure cadence:** with continuous green and count ≥ 1:
  - First `depart` pulse DEPART_CYCLES cycles after entering SERVE.
  - Subsequent pulses every DEPART_CYCLES cycles.
  - Count decrements one edge after each pulse.
- `X` falls one edge after the final `depart` pulse.

## Structure
- Shared package `traffic_pkg`:
  - Light-code constants RED / YELLOW / GREEN (2-bit), used by this block and the signal controller.
  - Departure FSM state encoding.
- One sub-module, `sensor_debounce` (params: DEBOUNCE_CYCLES; ports: `clock`, `clear_n`, `din`, `dout`). It contains the synchronizer and the debounce counter.
- The top level contains the arrival edge detector, departure FSM, queue counter and output decode.

## Test plan
- **Clean arrival:** hold `cntry` = RED; pulse `loop_raw` high for 10 cycles → one `arrive` pulse 6 edges after capture; `car_count` 0→1 one edge later; `X` = 1.
- **Glitch rejection:** 3-cycle `loop_raw` pulse with DEBOUNCE_CYCLES = 4 → no `arrive`; `car_count` stays 0; `X` stays 0.
- **Service:** count = 3, then `cntry` = GREEN held → `depart` at +3, +6, +9 cycles; count 3→2→1→0; `X` drops after the third; FSM returns to WAIT.
- **Interrupted service:** count = 2; GREEN for 2 cycles, then YELLOW → no `depart`, count stays 2; GREEN again → first `depart` a full 3 cycles later.
- **Simultaneous events:** align an `arrive` with a `depart` during GREEN at count 1 → count stays 1; `X` stays 1; `overflow` stays 0.
- **Saturation and reset:**
  - Drive 16 arrivals with `cntry` = RED → count saturates at 15; `overflow` = 1 on the 16th arrival.
  - Assert `clear_n` = 0 mid-SERVE → all outputs 0 immediately, without waiting for a clock edge.
